// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM->WB pipeline register for the multi-issue core.
// Holds a head and a skid bundle behind a registered mem_ready_o, so WB
// back-pressure never reaches MEM combinationally. The block also handles
// flush and keeps only the youngest writer of a register within a bundle.
// It drives the per-lane debug-commit port used by the difftest harness.
// Optional feature macro: DEBUG_COMMIT_EN. When it is defined, debug_commit_*
// are live and the 64-bit retire_count_o counter exists. When it is not
// defined, debug_commit_* are tied to 0 and retire_count_o is absent.

module mem_wb_pipe #(
    parameter int ISSUE_WIDTH = 2,
    parameter int REG_ADDR_W  = 5,
    parameter int DATA_W      = 32,
    parameter int PC_W        = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush_i,
    input  logic                              mem_valid_i,
    output logic                              mem_ready_o,
    input  logic [ISSUE_WIDTH-1:0]            mem_lane_valid_i,
    input  logic [ISSUE_WIDTH-1:0]            mem_wreg_i,
    input  logic [ISSUE_WIDTH*REG_ADDR_W-1:0] mem_wd_i,
    input  logic [ISSUE_WIDTH*DATA_W-1:0]     mem_wdata_i,
    input  logic [ISSUE_WIDTH*PC_W-1:0]       mem_pc_i,
    input  logic [ISSUE_WIDTH*PC_W-1:0]       mem_instr_i,
    input  logic                              wb_ready_i,
    output logic                              wb_valid_o,
    output logic [ISSUE_WIDTH-1:0]            wb_wreg_o,
    output logic [ISSUE_WIDTH*REG_ADDR_W-1:0] wb_wd_o,
    output logic [ISSUE_WIDTH*DATA_W-1:0]     wb_wdata_o,
    output logic [ISSUE_WIDTH-1:0]            debug_commit_valid_o,
    output logic [ISSUE_WIDTH*PC_W-1:0]       debug_commit_pc_o,
    output logic [ISSUE_WIDTH*PC_W-1:0]       debug_commit_instr_o
`ifdef DEBUG_COMMIT_EN
    ,
    output logic [63:0]                       retire_count_o
`endif
);

    localparam int W  = ISSUE_WIDTH;
    localparam int RA = REG_ADDR_W;
    localparam int DW = DATA_W;
    localparam int PW = PC_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    // One held bundle; kill marks lanes overwritten by a younger lane.
    typedef struct packed {
        logic [W-1:0]    lane_valid;
        logic [W-1:0]    wreg;
        logic [W-1:0]    kill;
        logic [W*RA-1:0] wd;
        logic [W*DW-1:0] wdata;
        logic [W*PW-1:0] pc;
        logic [W*PW-1:0] instr;
    } entry_t;

    occ_e         state_q, state_d;
    entry_t       head_q, head_d;
    entry_t       skid_q, skid_d;
    logic         head_vld_q, head_vld_d;
    logic         skid_vld_q, skid_vld_d;
    logic         mem_ready_q, mem_ready_d;
    logic [W-1:0] kill_in;
    entry_t       in_entry;
    logic         accept;
    logic         pop;
    logic         pop_eff;

    assign accept  = mem_valid_i & mem_ready_q;
    assign pop     = head_vld_q & wb_ready_i;
    assign pop_eff = pop & ~flush_i;

    // A lane is killed when a younger valid lane writes the same register.
    always_comb begin
        kill_in = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = i + 1; j < W; j++) begin
                if (mem_lane_valid_i[j] && mem_wreg_i[j] &&
                    (mem_wd_i[j*RA +: RA] == mem_wd_i[i*RA +: RA])) begin
                    kill_in[i] = 1'b1;
                end
            end
        end
    end

    // Package the incoming bundle together with its kill mask.
    always_comb begin
        in_entry            = '0;
        in_entry.lane_valid = mem_lane_valid_i;
        in_entry.wreg       = mem_wreg_i;
        in_entry.kill       = kill_in;
        in_entry.wd         = mem_wd_i;
        in_entry.wdata      = mem_wdata_i;
        in_entry.pc         = mem_pc_i;
        in_entry.instr      = mem_instr_i;
    end

    // Occupancy next-state: flush wins over accept and pop.
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        skid_d     = skid_q;
        head_vld_d = head_vld_q;
        skid_vld_d = skid_vld_q;
        if (flush_i) begin
            state_d    = EMPTY;
            head_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d    = ONE;
                        head_d     = in_entry;
                        head_vld_d = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_d = in_entry;
                    end else if (accept) begin
                        state_d    = FULL;
                        skid_d     = in_entry;
                        skid_vld_d = 1'b1;
                    end else if (pop) begin
                        state_d    = EMPTY;
                        head_vld_d = 1'b0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d    = ONE;
                        head_d     = skid_q;
                        head_vld_d = skid_vld_q;
                        skid_vld_d = 1'b0;
                    end
                end
                default: begin
                    state_d    = EMPTY;
                    head_vld_d = 1'b0;
                    skid_vld_d = 1'b0;
                end
            endcase
        end
        mem_ready_d = (state_d != FULL);
    end

    // Occupancy, entry storage and the registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            head_vld_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            mem_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            head_vld_q  <= head_vld_d;
            skid_vld_q  <= skid_vld_d;
            mem_ready_q <= mem_ready_d;
        end
    end

    assign mem_ready_o = mem_ready_q;
    assign wb_valid_o  = head_vld_q;
    assign wb_wd_o     = head_q.wd;
    assign wb_wdata_o  = head_q.wdata;
    assign wb_wreg_o   = {W{head_vld_q & wb_ready_i & ~flush_i}} &
                         head_q.lane_valid & head_q.wreg & ~head_q.kill;

`ifdef DEBUG_COMMIT_EN
    logic [W-1:0]    dbg_valid_q;
    logic [W*PW-1:0] dbg_pc_q;
    logic [W*PW-1:0] dbg_instr_q;
    logic [63:0]     retire_q;
    logic [63:0]     retire_inc;

    // Number of lanes retiring this cycle; killed lanes still count.
    always_comb begin
        retire_inc = '0;
        for (int i = 0; i < W; i++) begin
            retire_inc = retire_inc + {63'd0, dbg_valid_q[i]};
        end
    end

    // Debug commit lags the pop by one cycle; pc/instr hold between pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_valid_q <= '0;
            dbg_pc_q    <= '0;
            dbg_instr_q <= '0;
            retire_q    <= '0;
        end else begin
            dbg_valid_q <= pop_eff ? head_q.lane_valid : '0;
            if (pop_eff) begin
                dbg_pc_q    <= head_q.pc;
                dbg_instr_q <= head_q.instr;
            end
            retire_q <= retire_q + retire_inc;
        end
    end

    assign debug_commit_valid_o = dbg_valid_q;
    assign debug_commit_pc_o    = dbg_pc_q;
    assign debug_commit_instr_o = dbg_instr_q;
    assign retire_count_o       = retire_q;
`else
    logic unused_dbg;

    assign unused_dbg           = ^{head_q.pc, head_q.instr, pop_eff};
    assign debug_commit_valid_o = '0;
    assign debug_commit_pc_o    = '0;
    assign debug_commit_instr_o = '0;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: scoreboard bench for mem_wb_pipe. Expected bundles are
// pushed into a queue when the bench sees an accept, then popped and compared
// when the DUT pops them. The debug-commit expectations follow DEBUG_COMMIT_EN.

module tb_mem_wb_pipe;

    localparam int W  = 2;
    localparam int RA = 5;
    localparam int DW = 32;
    localparam int PW = 32;

`ifdef DEBUG_COMMIT_EN
    localparam bit DBG = 1'b1;
`else
    localparam bit DBG = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0]    lv;
        logic [W-1:0]    wr;
        logic [W*RA-1:0] wd;
        logic [W*DW-1:0] wdata;
        logic [W*PW-1:0] pc;
        logic [W*PW-1:0] instr;
    } bundle_t;

    typedef struct packed {
        logic [W-1:0]    lv;
        logic [W-1:0]    wreg;
        logic [W*RA-1:0] wd;
        logic [W*DW-1:0] wdata;
        logic [W*PW-1:0] pc;
        logic [W*PW-1:0] instr;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            memValid;
    logic            memReady;
    logic [W-1:0]    memLaneValid;
    logic [W-1:0]    memWreg;
    logic [W*RA-1:0] memWd;
    logic [W*DW-1:0] memWdata;
    logic [W*PW-1:0] memPc;
    logic [W*PW-1:0] memInstr;
    logic            wbReady;
    logic            wbValid;
    logic [W-1:0]    wbWreg;
    logic [W*RA-1:0] wbWd;
    logic [W*DW-1:0] wbWdata;
    logic [W-1:0]    dbgValid;
    logic [W*PW-1:0] dbgPc;
    logic [W*PW-1:0] dbgInstr;
`ifdef DEBUG_COMMIT_EN
    logic [63:0]     retireCount;
`endif

    int      checks = 0;
    int      errors = 0;
    exp_t    expQ[$];
    exp_t    e;
    bundle_t curB;
    bundle_t idle;
    logic [W-1:0]    pendLv;
    logic [W*PW-1:0] pendPc;
    logic            hadPop;
    int      npops;

    mem_wb_pipe #(
        .ISSUE_WIDTH(W),
        .REG_ADDR_W (RA),
        .DATA_W     (DW),
        .PC_W       (PW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush_i             (flush),
        .mem_valid_i         (memValid),
        .mem_ready_o         (memReady),
        .mem_lane_valid_i    (memLaneValid),
        .mem_wreg_i          (memWreg),
        .mem_wd_i            (memWd),
        .mem_wdata_i         (memWdata),
        .mem_pc_i            (memPc),
        .mem_instr_i         (memInstr),
        .wb_ready_i          (wbReady),
        .wb_valid_o          (wbValid),
        .wb_wreg_o           (wbWreg),
        .wb_wd_o             (wbWd),
        .wb_wdata_o          (wbWdata),
        .debug_commit_valid_o(dbgValid),
        .debug_commit_pc_o   (dbgPc),
        .debug_commit_instr_o(dbgInstr)
`ifdef DEBUG_COMMIT_EN
        ,
        .retire_count_o      (retireCount)
`endif
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout got running want finished");
        $fatal(1, "[TB] watchdog");
    end

    // Reference behaviour: only the youngest valid writer of a register writes.
    function automatic exp_t model(input bundle_t b);
        exp_t r;
        logic killed;
        r.lv    = b.lv;
        r.wd    = b.wd;
        r.wdata = b.wdata;
        r.pc    = b.pc;
        r.instr = b.instr;
        r.wreg  = '0;
        for (int i = 0; i < W; i++) begin
            killed = 1'b0;
            for (int j = i + 1; j < W; j++) begin
                if (b.lv[j] && b.wr[j] && (b.wd[j*RA +: RA] == b.wd[i*RA +: RA])) begin
                    killed = 1'b1;
                end
            end
            r.wreg[i] = b.lv[i] & b.wr[i] & ~killed;
        end
        return r;
    endfunction

    // Build a bundle with tag-derived pc/instr so every bundle is distinct.
    function automatic bundle_t mk(input logic [1:0] lv, input logic [1:0] wr,
                                   input logic [4:0] wd0, input logic [4:0] wd1,
                                   input logic [31:0] d0, input logic [31:0] d1,
                                   input int tag);
        bundle_t b;
        b.lv    = lv;
        b.wr    = wr;
        b.wd    = {wd1, wd0};
        b.wdata = {d1, d0};
        b.pc    = {32'h1000 + 32'(tag * 8) + 32'd4, 32'h1000 + 32'(tag * 8)};
        b.instr = {32'hC0DE0000 | 32'(tag * 2 + 1), 32'hC0DE0000 | 32'(tag * 2)};
        return b;
    endfunction

    // Put a bundle and the control inputs onto the DUT pins.
    task automatic drive(input bundle_t b, input logic mv, input logic wr, input logic fl);
        curB         = b;
        memValid     = mv;
        memLaneValid = b.lv;
        memWreg      = b.wr;
        memWd        = b.wd;
        memWdata     = b.wdata;
        memPc        = b.pc;
        memInstr     = b.instr;
        wbReady      = wr;
        flush        = fl;
    endtask

    // Record an accept into the scoreboard, then move to just after the next edge.
    task automatic advance(output logic acc);
        acc = memValid && memReady && !flush && !rst;
        if (flush || rst) expQ.delete();
        else if (acc) expQ.push_back(model(curB));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic acc;
        rst = 1'b1;
        drive(idle, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (memReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_mem_ready got %b want 1", memReady); end
        checks++;
        if (wbValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_valid got %b want 0", wbValid); end
        checks++;
        if (wbWreg !== '0 || wbWd !== '0 || wbWdata !== '0) begin
            errors++; $display("[TB] FAIL reset_wb_data got wreg=%b wd=%h wdata=%h want all 0", wbWreg, wbWd, wbWdata);
        end
        checks++;
        if (dbgValid !== '0 || dbgPc !== '0 || dbgInstr !== '0) begin
            errors++; $display("[TB] FAIL reset_debug got v=%b pc=%h instr=%h want all 0", dbgValid, dbgPc, dbgInstr);
        end
`ifdef DEBUG_COMMIT_EN
        checks++;
        if (retireCount !== 64'd0) begin errors++; $display("[TB] FAIL reset_retire got %0d want 0", retireCount); end
`endif
        expQ.delete();
        rst = 1'b0;
        advance(acc);
    endtask

    task automatic test_basic();
        logic acc;
        bundle_t b;
        b = mk(2'b11, 2'b11, 5'd5, 5'd3, 32'hB, 32'hA, 1);
        drive(b, 1'b1, 1'b1, 1'b0);
        #1;
        checks++;
        if (memReady !== 1'b1) begin errors++; $display("[TB] FAIL basic_ready got %b want 1", memReady); end
        advance(acc);
        drive(idle, 1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if (wbValid !== 1'b1) begin errors++; $display("[TB] FAIL basic_latency got wb_valid=%b want 1", wbValid); end
        checks++;
        if (wbWreg !== 2'b11) begin errors++; $display("[TB] FAIL basic_wreg got %b want 11", wbWreg); end
        if (wbValid && wbReady) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++; $display("[TB] FAIL basic_pop got wd=%h want no bundle", wbWd);
            end else begin
                e = expQ.pop_front();
                if ({wbWreg, wbWd, wbWdata} !== {e.wreg, e.wd, e.wdata}) begin
                    errors++;
                    $display("[TB] FAIL basic_pop got wreg=%b wd=%h wdata=%h want wreg=%b wd=%h wdata=%h",
                             wbWreg, wbWd, wbWdata, e.wreg, e.wd, e.wdata);
                end
            end
        end
        advance(acc);
        drive(idle, 1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if (dbgValid !== (DBG ? 2'b11 : 2'b00)) begin
            errors++; $display("[TB] FAIL basic_dbg_valid got %b want %b", dbgValid, DBG ? 2'b11 : 2'b00);
        end
        checks++;
        if (dbgPc !== (DBG ? b.pc : 64'd0) || dbgInstr !== (DBG ? b.instr : 64'd0)) begin
            errors++; $display("[TB] FAIL basic_dbg_pc got pc=%h instr=%h want pc=%h instr=%h",
                               dbgPc, dbgInstr, DBG ? b.pc : 64'd0, DBG ? b.instr : 64'd0);
        end
        checks++;
        if (wbValid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drained got wb_valid=%b want 0", wbValid); end
        advance(acc);
    endtask

    task automatic test_backpressure();
        logic acc;
        bundle_t bs[3];
        int idx;
        for (int i = 0; i < 3; i++) begin
            bs[i] = mk(2'b11, 2'b11, 5'(2 * i + 1), 5'(2 * i + 2), 32'(16'hB000 + i), 32'(16'hC000 + i), 10 + i);
        end
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            drive(bs[idx], 1'b1, 1'b0, 1'b0);
            #1;
            checks++;
            if (memReady !== (c < 2)) begin errors++; $display("[TB] FAIL bp_ready cycle %0d got %b want %b", c, memReady, c < 2); end
            checks++;
            if (wbValid !== (c > 0)) begin errors++; $display("[TB] FAIL bp_valid cycle %0d got %b want %b", c, wbValid, c > 0); end
            advance(acc);
            if (acc) idx++;
        end
        checks++;
        if (idx != 2) begin errors++; $display("[TB] FAIL bp_accepted got %0d want 2", idx); end
        npops  = 0;
        pendLv = '0;
        pendPc = '0;
        hadPop = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (idx < 3) drive(bs[idx], 1'b1, 1'b1, 1'b0);
            else drive(idle, 1'b0, 1'b1, 1'b0);
            #1;
            checks++;
            if (dbgValid !== (DBG ? pendLv : 2'b00)) begin
                errors++; $display("[TB] FAIL bp_dbg_valid got %b want %b", dbgValid, DBG ? pendLv : 2'b00);
            end
            if (hadPop) begin
                checks++;
                if (dbgPc !== (DBG ? pendPc : 64'd0)) begin
                    errors++; $display("[TB] FAIL bp_dbg_pc got %h want %h", dbgPc, DBG ? pendPc : 64'd0);
                end
            end
            pendLv = '0;
            hadPop = 1'b0;
            if (wbValid && wbReady) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++; $display("[TB] FAIL bp_pop got wd=%h want no bundle", wbWd);
                end else begin
                    e = expQ.pop_front();
                    if ({wbWreg, wbWd, wbWdata} !== {e.wreg, e.wd, e.wdata}) begin
                        errors++;
                        $display("[TB] FAIL bp_pop got wreg=%b wd=%h wdata=%h want wreg=%b wd=%h wdata=%h",
                                 wbWreg, wbWd, wbWdata, e.wreg, e.wd, e.wdata);
                    end
                    pendLv = e.lv;
                    pendPc = e.pc;
                    hadPop = 1'b1;
                    npops++;
                end
            end
            advance(acc);
            if (acc) idx++;
        end
        checks++;
        if (npops != 3 || idx != 3) begin errors++; $display("[TB] FAIL bp_drain got pops=%0d accepted=%0d want 3 3", npops, idx); end
    endtask

    task automatic test_back_to_back();
        logic acc;
        bundle_t pats[6];
        int idx;
        pats[0] = mk(2'b11, 2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 20);
        pats[1] = mk(2'b11, 2'b01, 5'd7, 5'd7, 32'h33, 32'h44, 21);
        pats[2] = mk(2'b01, 2'b11, 5'd9, 5'd9, 32'h55, 32'h66, 22);
        pats[3] = mk(2'b11, 2'b11, 5'd0, 5'd3, 32'h77, 32'h88, 23);
        pats[4] = mk(2'b10, 2'b11, 5'd4, 5'd4, 32'h99, 32'hAA, 24);
        pats[5] = mk(2'b11, 2'b11, 5'd0, 5'd0, 32'hBB, 32'hCC, 25);
        idx    = 0;
        npops  = 0;
        pendLv = '0;
        pendPc = '0;
        hadPop = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (idx < 6) drive(pats[idx], 1'b1, 1'b1, 1'b0);
            else drive(idle, 1'b0, 1'b1, 1'b0);
            #1;
            checks++;
            if (dbgValid !== (DBG ? pendLv : 2'b00)) begin
                errors++; $display("[TB] FAIL b2b_dbg_valid got %b want %b", dbgValid, DBG ? pendLv : 2'b00);
            end
            if (hadPop) begin
                checks++;
                if (dbgPc !== (DBG ? pendPc : 64'd0)) begin
                    errors++; $display("[TB] FAIL b2b_dbg_pc got %h want %h", dbgPc, DBG ? pendPc : 64'd0);
                end
            end
            pendLv = '0;
            hadPop = 1'b0;
            if (wbValid && wbReady) begin
                if (npops == 0) begin
                    checks++;
                    if (wbWreg !== 2'b10 || wbWdata[DW +: DW] !== 32'h22) begin
                        errors++; $display("[TB] FAIL conflict_wreg got wreg=%b lane1=%h want wreg=10 lane1=22",
                                           wbWreg, wbWdata[DW +: DW]);
                    end
                end
                checks++;
                if (expQ.size() == 0) begin
                    errors++; $display("[TB] FAIL b2b_pop got wd=%h want no bundle", wbWd);
                end else begin
                    e = expQ.pop_front();
                    if ({wbWreg, wbWd, wbWdata} !== {e.wreg, e.wd, e.wdata}) begin
                        errors++;
                        $display("[TB] FAIL b2b_pop got wreg=%b wd=%h wdata=%h want wreg=%b wd=%h wdata=%h",
                                 wbWreg, wbWd, wbWdata, e.wreg, e.wd, e.wdata);
                    end
                    pendLv = e.lv;
                    pendPc = e.pc;
                    hadPop = 1'b1;
                    npops++;
                end
            end
            advance(acc);
            if (acc) idx++;
        end
        checks++;
        if (npops != 6) begin errors++; $display("[TB] FAIL b2b_count got %0d want 6", npops); end
    endtask

    task automatic test_flush();
        logic acc;
        drive(mk(2'b11, 2'b11, 5'd1, 5'd2, 32'h1, 32'h2, 30), 1'b1, 1'b0, 1'b0);
        #1;
        advance(acc);
        drive(mk(2'b11, 2'b11, 5'd3, 5'd4, 32'h3, 32'h4, 31), 1'b1, 1'b0, 1'b0);
        #1;
        advance(acc);
        drive(mk(2'b11, 2'b11, 5'd5, 5'd6, 32'h5, 32'h6, 32), 1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if (memReady !== 1'b0) begin errors++; $display("[TB] FAIL flush_full got ready=%b want 0", memReady); end
        checks++;
        if (wbWreg !== 2'b00) begin errors++; $display("[TB] FAIL flush_wreg got %b want 00", wbWreg); end
        advance(acc);
        for (int c = 0; c < 3; c++) begin
            drive(idle, 1'b0, 1'b1, 1'b0);
            #1;
            checks++;
            if (wbValid !== 1'b0 || memReady !== 1'b1 || dbgValid !== 2'b00 || wbWreg !== 2'b00) begin
                errors++; $display("[TB] FAIL flush_after cycle %0d got valid=%b ready=%b dbg=%b wreg=%b want 0 1 00 00",
                                   c, wbValid, memReady, dbgValid, wbWreg);
            end
            advance(acc);
        end
    endtask

    task automatic test_reset_mid();
        logic acc;
        drive(mk(2'b11, 2'b11, 5'd8, 5'd9, 32'h8, 32'h9, 40), 1'b1, 1'b0, 1'b0);
        #1;
        advance(acc);
        drive(mk(2'b11, 2'b11, 5'd10, 5'd11, 32'hA0, 32'hB0, 41), 1'b1, 1'b0, 1'b0);
        #1;
        advance(acc);
        checks++;
        if (memReady !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_full got ready=%b want 0", memReady); end
        rst = 1'b1;
        drive(mk(2'b11, 2'b11, 5'd12, 5'd13, 32'hC0, 32'hD0, 42), 1'b1, 1'b1, 1'b0);
        #1;
        advance(acc);
        rst = 1'b0;
        drive(idle, 1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if (wbValid !== 1'b0 || wbWreg !== '0 || wbWd !== '0 || wbWdata !== '0) begin
            errors++; $display("[TB] FAIL rstmid_wb got valid=%b wreg=%b wd=%h wdata=%h want all 0",
                               wbValid, wbWreg, wbWd, wbWdata);
        end
        checks++;
        if (dbgValid !== '0 || dbgPc !== '0 || dbgInstr !== '0 || memReady !== 1'b1) begin
            errors++; $display("[TB] FAIL rstmid_dbg got v=%b pc=%h instr=%h ready=%b want 0 0 0 1",
                               dbgValid, dbgPc, dbgInstr, memReady);
        end
`ifdef DEBUG_COMMIT_EN
        checks++;
        if (retireCount !== 64'd0) begin errors++; $display("[TB] FAIL rstmid_retire got %0d want 0", retireCount); end
`endif
        for (int c = 0; c < 2; c++) begin
            advance(acc);
            checks++;
            if (wbValid !== 1'b0 || dbgValid !== 2'b00) begin
                errors++; $display("[TB] FAIL rstmid_after cycle %0d got valid=%b dbg=%b want 0 00", c, wbValid, dbgValid);
            end
        end
    endtask

    task automatic test_retire();
        logic acc;
        int idx;
        int seen;
        rst = 1'b1;
        drive(idle, 1'b0, 1'b0, 1'b0);
        advance(acc);
        rst  = 1'b0;
        idx  = 0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (idx < 11) drive(mk((idx < 10) ? 2'b11 : 2'b01, 2'b11, 5'(idx), 5'(idx + 1),
                                  32'(idx), 32'(idx + 100), 50 + idx), 1'b1, 1'b1, 1'b0);
            else drive(idle, 1'b0, 1'b1, 1'b0);
            #1;
            seen += $countones(dbgValid);
            advance(acc);
            if (acc) idx++;
        end
        expQ.delete();
        checks++;
        if (seen != (DBG ? 21 : 0)) begin errors++; $display("[TB] FAIL retire_lanes got %0d want %0d", seen, DBG ? 21 : 0); end
`ifdef DEBUG_COMMIT_EN
        checks++;
        if (retireCount !== 64'd21) begin errors++; $display("[TB] FAIL retire_count got %0d want 21", retireCount); end
`endif
    endtask

    // Run every scenario in order and print the summary.
    initial begin
        idle = '0;
        rst  = 1'b1;
        drive(idle, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_retire();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
Parametrised MEM->WB pipeline register for the multi-issue core. It carries a bundle of ISSUE_WIDTH lanes and uses a valid/ready handshake with a 2-entry skid buffer, so WB back-pressure never creates a combinational ready path into MEM. It also handles flush, resolves same-register writes within a bundle, and drives the per-lane debug-commit interface used by the difftest harness.

Parameters:
ISSUE_WIDTH, 2, lanes per bundle; lane 0 is the oldest instruction.
REG_ADDR_W, 5, register address width.
DATA_W, 32, register data width.
PC_W, 32, PC and instruction width.

Ports:
clk  in  1  clock.
rst  in  1  reset; synchronous, active-high.
flush  in  1  discard all held and incoming bundles.
mem_valid  in  1  MEM offers a bundle.
mem_ready  out  1  this stage accepts; registered, not combinational from wb_ready.
mem_lane_valid  in  ISSUE_WIDTH  per-lane instruction valid.
mem_wreg  in  ISSUE_WIDTH  per-lane register-write enable.
mem_wd  in  ISSUE_WIDTH*REG_ADDR_W  per-lane destination register, lane i at [i*REG_ADDR_W +: REG_ADDR_W].
mem_wdata  in  ISSUE_WIDTH*DATA_W  per-lane write data.
mem_pc  in  ISSUE_WIDTH*PC_W  per-lane PC.
mem_instr  in  ISSUE_WIDTH*PC_W  per-lane instruction word.
wb_ready  in  1  WB / regfile accepts the head bundle.
wb_valid  out  1  head bundle is valid.
wb_wreg  out  ISSUE_WIDTH  per-lane write enable after gating.
wb_wd  out  ISSUE_WIDTH*REG_ADDR_W  per-lane destination register.
wb_wdata  out  ISSUE_WIDTH*DATA_W  per-lane write data.
debug_commit_valid  out  ISSUE_WIDTH  lane retired this cycle.
debug_commit_pc  out  ISSUE_WIDTH*PC_W  retired PC.
debug_commit_instr  out  ISSUE_WIDTH*PC_W  retired instruction word.
retire_count  out  64  total retired instructions (present only with DEBUG_COMMIT_EN).

Behaviour:
- Storage: a head entry and a skid entry. Each entry holds a valid flag plus a full bundle.
- Occupancy states: EMPTY, ONE (head only), FULL (head and skid).
- mem_ready is a register: 1 in EMPTY and ONE, 0 in FULL.
- Accept = mem_valid & mem_ready. Pop = wb_valid & wb_ready.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept, no pop -> FULL; incoming bundle goes to skid.
  - ONE + accept + pop -> ONE; incoming bundle replaces head.
  - ONE + pop, no accept -> EMPTY.
  - FULL + pop -> ONE; skid moves to head.
  - FULL + no pop -> FULL.
- Latency: a bundle accepted at edge N is visible on wb_* after edge N (one cycle) when the stage was EMPTY, or when it was ONE and popped in the same cycle.
- Ordering: bundles leave strictly in arrival order. Lanes are never reordered.
- wb_valid is 1 iff the head entry is valid.
- Write gating: wb_wreg[i] = wb_valid & wb_ready & lane_valid[i] & wreg[i] & ~killed[i].
- killed[i] is 1 when some younger lane j > i in the same bundle is valid, has wreg set, and has the same wd. Only the youngest writer of a register commits; the kill mask is computed at accept time and stored with the entry.
- A lane with wreg=1 and wd=0 is still asserted; register 0 is masked in the regfile.
- flush: at the next edge both entries become invalid, the stage goes to EMPTY and mem_ready=1.
  - flush takes priority over an accept and over a pop in the same cycle.
  - wb_wreg and debug_commit_valid are forced to 0 in the flush cycle.
- Reset: all entries are invalid and mem_ready=1.
  - Every output is 0: wb_valid, wb_wreg, wb_wd, wb_wdata, debug_commit_*, retire_count.
  - Reset mid-operation drops held bundles with no commit.
- debug_commit_* are registered from the pop event and lag wb_* by one cycle:
  - debug_commit_valid[i] <= pop & lane_valid[i] & ~flush; otherwise 0.
  - debug_commit_pc and debug_commit_instr are loaded only on pop and hold otherwise.
- Killed lanes still retire on debug_commit_valid, because they are executed instructions; only their register write is suppressed.

Optional Feature:
DEBUG_COMMIT_EN.
- Defined: retire_count exists. It is a 64-bit counter that increments by popcount(debug_commit_valid) every cycle, wraps modulo 2^64, and is cleared by rst.
- Not defined: the retire_count port and its logic are absent; debug_commit_* are tied to 0.

Test Plan:
1. Reset, then mem_valid=1 with lane_valid=2'b11, wd={3,5}, wdata={0xA,0xB}, wreg=2'b11, wb_ready=1 -> next cycle wb_valid=1, wb_wreg=2'b11; the cycle after, debug_commit_valid=2'b11.
2. Back-pressure: wb_ready=0 while three bundles B0,B1,B2 are offered -> B0 and B1 accepted, mem_ready=0 from the third cycle, B2 held. Then wb_ready=1 -> wb_* emits B0, B1, B2 in order with no loss.
3. Intra-bundle conflict: both lanes have wd=7, wreg=1, wdata={0x11,0x22} -> wb_wreg=2'b10, wb_wdata lane1=0x22, debug_commit_valid=2'b11.
4. Flush while FULL, with mem_valid=1 in the same cycle -> next cycle wb_valid=0, mem_ready=1, no wb_wreg and no debug_commit_valid for any held or incoming bundle.
5. rst asserted while FULL and wb_ready=1 -> all outputs 0 on the next cycle; the incoming bundle is not accepted.
6. With DEBUG_COMMIT_EN: 10 full bundles plus 1 bundle with lane_valid=2'b01 -> retire_count=21.
